// File: rtl/prog_clock_divider_if.sv
// -----------------------------------------------------------------------------
// prog_clock_divider_if
//   Control/status bundle for the programmable clock divider.
//
//   Signals (CHANNELS wide unless noted; slice i of a packed field is
//   [i*WIDTH +: WIDTH]):
//     en         per-channel run enable
//     load       per-channel configuration load strobe
//     period_in  CHANNELS*WIDTH, period minus one
//     high_in    CHANNELS*WIDTH, high time in cycles
//     clk_out    divided clocks (registered)
//     tick       one-cycle pulse on the first cycle of each period (registered)
//     pending    a loaded configuration waits for the next period boundary
//
//   Modports:
//     master  the controller: drives en/load/period_in/high_in
//     slave   the divider: drives clk_out/tick/pending
// -----------------------------------------------------------------------------
interface prog_clock_divider_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] period_in;
    logic [CHANNELS*WIDTH-1:0] high_in;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       pending;

    modport master (
        output en, load, period_in, high_in,
        input  clk_out, tick, pending
    );

    modport slave (
        input  en, load, period_in, high_in,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/prog_clock_divider.sv
// -----------------------------------------------------------------------------
// prog_clock_divider
//   Multi-channel runtime-programmable clock divider. Each channel produces a
//   divided clock of N = P+1 cycles with H high cycles at the start of each
//   period, plus a registered period-start tick. New configurations are held
//   in a shadow register and only take effect on a period boundary, so the
//   output never shows a runt pulse.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   prog_clock_divider_if.slave (en, load, period_in, high_in in;
//           clk_out, tick, pending out)
// -----------------------------------------------------------------------------
module prog_clock_divider #(
    parameter int          CHANNELS     = 2,
    parameter int          WIDTH        = 16,
    parameter int unsigned RESET_PERIOD = 127,
    parameter int unsigned RESET_HIGH   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    prog_clock_divider_if.slave   bus
);

    localparam logic [WIDTH-1:0] RST_P = WIDTH'(RESET_PERIOD);
    localparam logic [WIDTH-1:0] RST_H = WIDTH'(RESET_HIGH);

    logic [CHANNELS-1:0] clk_out_v;
    logic [CHANNELS-1:0] tick_v;
    logic [CHANNELS-1:0] pending_v;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] p_q, p_d, h_q, h_d;
        logic [WIDTH-1:0] ps_q, ps_d, hs_q, hs_d;
        logic             pend_q, pend_d;
        logic             run_q, run_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic [WIDTH-1:0] period_s, high_s;
        logic             wrap;
        logic             boundary;

        always_comb begin
            // NOTE: every variable gets a default before any branch so no
            // path leaves it unassigned, which would infer a latch.
            period_s = bus.period_in[ch*WIDTH +: WIDTH];
            high_s   = bus.high_in[ch*WIDTH +: WIDTH];
            p_d      = p_q;
            h_d      = h_q;
            ps_d     = ps_q;
            hs_d     = hs_q;
            pend_d   = pend_q;
            run_d    = 1'b0;
            cnt_d    = '0;
            clk_d    = 1'b0;
            tick_d   = 1'b0;

            wrap = run_q && (cnt_q == p_q);
            // Configuration may change whenever this edge does not continue
            // an ongoing period: a wrap, a start, or any non-running edge.
            boundary = !(bus.en[ch] && run_q && !wrap);

            if (bus.load[ch]) begin
                ps_d = period_s;
                hs_d = high_s;
                if (boundary) begin
                    // Bypass the shadow: the new period uses this config.
                    p_d    = period_s;
                    h_d    = high_s;
                    pend_d = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end else if (pend_q && boundary) begin
                p_d    = ps_q;
                h_d    = hs_q;
                pend_d = 1'b0;
            end

            if (bus.en[ch]) begin
                run_d  = 1'b1;
                tick_d = !run_q || wrap;
                cnt_d  = tick_d ? '0 : cnt_q + WIDTH'(1);
                // Compare the next count against the high time in force for
                // that cycle so outputs move on the same edge as the counter.
                clk_d  = cnt_d < h_d;
            end
        end

        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        // NOTE: all state, including the active and shadow configuration,
        // is reset so an aborted pending load is discarded.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                p_q    <= RST_P;
                h_q    <= RST_H;
                ps_q   <= RST_P;
                hs_q   <= RST_H;
                pend_q <= 1'b0;
                run_q  <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                p_q    <= p_d;
                h_q    <= h_d;
                ps_q   <= ps_d;
                hs_q   <= hs_d;
                pend_q <= pend_d;
                run_q  <= run_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_out_v[ch] = clk_q;
        assign tick_v[ch]    = tick_q;
        assign pending_v[ch] = pend_q;
    end

    assign bus.clk_out = clk_out_v;
    assign bus.tick    = tick_v;
    assign bus.pending = pending_v;

endmodule

// File: tb/tb_prog_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clock_divider
//   Directed bench for prog_clock_divider (CHANNELS=2, WIDTH=16, reset config
//   P=127/H=64). Inputs change 1 time unit after a rising edge and outputs are
//   sampled at that same point, i.e. they reflect the edge just taken.
//   Expected values follow from the per-period rule clk_out=(k<H), tick=(k==0)
//   with N, H and the phase k written out by hand at each step.
// -----------------------------------------------------------------------------
module tb_prog_clock_divider;

    localparam int CH = 2;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    prog_clock_divider_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    prog_clock_divider #(
        .CHANNELS(CH), .WIDTH(W), .RESET_PERIOD(127), .RESET_HIGH(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Check one channel at phase k of a period with high time h.
    task automatic chk_ch(input int ch, input int h, input int k,
                          input logic pend, input string tag);
        check($sformatf("%s ch%0d k=%0d clk_out", tag, ch, k), bus.clk_out[ch], logic'(k < h));
        check($sformatf("%s ch%0d k=%0d tick", tag, ch, k), bus.tick[ch], logic'(k == 0));
        check($sformatf("%s ch%0d k=%0d pending", tag, ch, k), bus.pending[ch], pend);
    endtask

    task automatic chk_off(input int ch, input string tag);
        check($sformatf("%s ch%0d clk_out", tag, ch), bus.clk_out[ch], 1'b0);
        check($sformatf("%s ch%0d tick", tag, ch), bus.tick[ch], 1'b0);
    endtask

    // Take ncyc edges; cycle i sits at phase (k0+i) mod n.
    task automatic run_chk(input int ch, input int ncyc, input int n, input int h,
                           input int k0, input logic pend, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            edge_step();
            chk_ch(ch, h, (k0 + i) % n, pend, tag);
        end
    endtask

    task automatic set_cfg(input int ch, input int p, input int h);
        bus.period_in[ch*W +: W] = W'(p);
        bus.high_in[ch*W +: W]   = W'(h);
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = '0;
        bus.load      = '0;
        bus.period_in = '0;
        bus.high_in   = '0;

        // Reset state.
        edge_step();
        edge_step();
        for (int c = 0; c < CH; c++) begin
            chk_off(c, "reset");
            check($sformatf("reset ch%0d pending", c), bus.pending[c], 1'b0);
        end
        rst = 1'b0;

        // Reset defaults: 128-cycle period, 64 high, two full periods.
        bus.en[0] = 1'b1;
        run_chk(0, 256, 128, 64, 0, 1'b0, "default");
        chk_off(1, "ch1 idle");

        // Runtime reload mid-period: old period completes, then 10/3.
        run_chk(0, 20, 128, 64, 0, 1'b0, "pre_load");
        set_cfg(0, 9, 3);
        bus.load[0] = 1'b1;
        run_chk(0, 1, 128, 64, 20, 1'b1, "load_edge");
        bus.load[0] = 1'b0;
        run_chk(0, 107, 128, 64, 21, 1'b1, "old_period");
        run_chk(0, 30, 10, 3, 0, 1'b0, "reloaded");

        // Load on the exact wrap edge bypasses the shadow: 6/2.
        set_cfg(0, 5, 2);
        bus.load[0] = 1'b1;
        run_chk(0, 1, 6, 2, 0, 1'b0, "collide");
        bus.load[0] = 1'b0;
        run_chk(0, 17, 6, 2, 1, 1'b0, "collide_run");

        // Two loads before a boundary: only the second (8/5) applies.
        run_chk(0, 2, 6, 2, 0, 1'b0, "dbl_pre");
        set_cfg(0, 3, 1);
        bus.load[0] = 1'b1;
        run_chk(0, 1, 6, 2, 2, 1'b1, "dbl_load1");
        set_cfg(0, 7, 5);
        run_chk(0, 1, 6, 2, 3, 1'b1, "dbl_load2");
        bus.load[0] = 1'b0;
        run_chk(0, 2, 6, 2, 4, 1'b1, "dbl_wait");
        run_chk(0, 16, 8, 5, 0, 1'b0, "dbl_applied");

        // N=1, H=1: constant high, tick every cycle.
        set_cfg(0, 0, 1);
        bus.load[0] = 1'b1;
        run_chk(0, 1, 1, 1, 0, 1'b0, "n1_h1");
        bus.load[0] = 1'b0;
        run_chk(0, 9, 1, 1, 0, 1'b0, "n1_h1");

        // H=0: constant low.
        set_cfg(0, 0, 0);
        bus.load[0] = 1'b1;
        run_chk(0, 1, 1, 0, 0, 1'b0, "h0");
        bus.load[0] = 1'b0;
        run_chk(0, 5, 1, 0, 0, 1'b0, "h0");

        // H >= N: constant high, tick every 5 cycles.
        set_cfg(0, 4, 9);
        bus.load[0] = 1'b1;
        run_chk(0, 1, 5, 9, 0, 1'b0, "h_ge_n");
        bus.load[0] = 1'b0;
        run_chk(0, 14, 5, 9, 1, 1'b0, "h_ge_n");

        // Disable at k=3, re-enable restarts at k=0.
        run_chk(0, 4, 5, 9, 0, 1'b0, "to_k3");
        bus.en[0] = 1'b0;
        edge_step();
        chk_off(0, "disabled");
        edge_step();
        chk_off(0, "disabled2");
        bus.en[0] = 1'b1;
        run_chk(0, 7, 5, 9, 0, 1'b0, "reenable");

        // Reset with a pending load reverts to the reset configuration.
        set_cfg(0, 9, 3);
        bus.load[0] = 1'b1;
        run_chk(0, 1, 5, 9, 2, 1'b1, "pend_before_rst");
        bus.load[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_off(0, "async_rst");
        check("async_rst ch0 pending", bus.pending[0], 1'b0);
        edge_step();
        rst = 1'b0;
        run_chk(0, 130, 128, 64, 0, 1'b0, "post_rst");

        // Channel independence: ch0 2/1, ch1 7/3, loaded while disabled.
        bus.en = 2'b00;
        set_cfg(0, 1, 1);
        set_cfg(1, 6, 3);
        bus.load = 2'b11;
        edge_step();
        chk_off(0, "idle_load");
        chk_off(1, "idle_load");
        check("idle_load ch0 pending", bus.pending[0], 1'b0);
        check("idle_load ch1 pending", bus.pending[1], 1'b0);
        bus.load = 2'b00;
        bus.en   = 2'b11;
        for (int i = 0; i < 16; i++) begin
            edge_step();
            chk_ch(0, 1, i % 2, 1'b0, "indep");
            chk_ch(1, 3, i % 7, 1'b0, "indep");
        end
        // Load ch1 at its k=2 with 3/2; ch0 must be unaffected.
        set_cfg(1, 2, 2);
        bus.load[1] = 1'b1;
        edge_step();
        chk_ch(0, 1, 0, 1'b0, "indep_load");
        chk_ch(1, 3, 2, 1'b1, "indep_load");
        bus.load[1] = 1'b0;
        for (int i = 17; i < 21; i++) begin
            edge_step();
            chk_ch(0, 1, i % 2, 1'b0, "indep_wait");
            chk_ch(1, 3, i % 7, 1'b1, "indep_wait");
        end
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk_ch(0, 1, (i + 21) % 2, 1'b0, "indep_new");
            chk_ch(1, 2, i % 3, 1'b0, "indep_new");
        end
        // Disable ch0; ch1 keeps its 3/2 waveform.
        bus.en[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            edge_step();
            chk_off(0, "ch0_off");
            chk_ch(1, 2, i % 3, 1'b0, "ch1_alone");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
